// File: rtl/matrix_tile_unloader_if.sv
// matrix_tile_unloader_if: tile capture port plus element stream port of the tile unloader
//   slave  (unloader side): takes tile_val/tile_elements/tile_addr/col_major/out_ready,
//                           drives tile_rdy/out_valid/out_data/out_row/out_col/out_addr/out_last/busy
//   master (environment side): the mirror image
interface matrix_tile_unloader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_MG = 64,
    parameter int NUM_PE = NUM_MG,
    parameter int ADDR_WIDTH = 64
);
    logic tile_val;
    logic tile_rdy;
    logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] tile_elements;
    logic [ADDR_WIDTH-1:0] tile_addr;
    logic col_major;
    logic out_valid;
    logic out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [$clog2(NUM_MG)-1:0] out_row;
    logic [$clog2(NUM_PE)-1:0] out_col;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic out_last;
    logic busy;
    modport slave (
        input tile_val, tile_elements, tile_addr, col_major, out_ready,
        output tile_rdy, out_valid, out_data, out_row, out_col, out_addr, out_last, busy
    );
    modport master (
        output tile_val, tile_elements, tile_addr, col_major, out_ready,
        input tile_rdy, out_valid, out_data, out_row, out_col, out_addr, out_last, busy
    );
endinterface

// File: rtl/matrix_tile_unloader.sv
// matrix_tile_unloader: captures a NUM_MG x NUM_PE tile in one cycle and streams it out element by element
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave modport; tile_val/tile_rdy capture handshake with tile_elements/tile_addr/col_major,
//              out_valid/out_ready element stream with out_data/out_row/out_col/out_addr/out_last, busy
module matrix_tile_unloader #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_MG = 64,
    parameter int NUM_PE = NUM_MG,
    parameter int ADDR_WIDTH = 64
) (
    input logic clk,
    input logic rst,
    matrix_tile_unloader_if.slave bus
);
    localparam int TOTAL = NUM_MG * NUM_PE;
    localparam int IW = $clog2(TOTAL);
    localparam int RW = $clog2(NUM_MG);
    localparam int CW = $clog2(NUM_PE);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_next;
    logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] tile_buf;
    logic [ADDR_WIDTH-1:0] base;
    logic cm;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [IW-1:0] idx;
    logic stream, last, take, fire, row_end, col_end, row_step, col_step;
    always_comb begin
        stream = state == STREAM;
        last = stream && idx == IW'(TOTAL - 1);
        take = bus.tile_val && state == IDLE && !rst;
        fire = stream && bus.out_ready;
        row_end = row == RW'(NUM_MG - 1);
        col_end = col == CW'(NUM_PE - 1);
        // the fast-moving index always steps; the slow one steps when the fast one wraps
        row_step = cm ? 1'b1 : col_end;
        col_step = cm ? row_end : 1'b1;
        state_next = state == IDLE ? (take ? STREAM : IDLE) : (fire && last ? IDLE : STREAM);
    end
    always_comb begin
        bus.tile_rdy = state == IDLE && !rst;
        bus.busy = stream;
        bus.out_valid = stream;
        bus.out_last = last;
        bus.out_data = stream ? tile_buf[row][col] : '0;
        bus.out_row = stream ? row : '0;
        bus.out_col = stream ? col : '0;
        bus.out_addr = stream ? base + ADDR_WIDTH'(idx) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base <= '0;
            cm <= 1'b0;
            row <= '0;
            col <= '0;
            idx <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                base <= bus.tile_addr;
                cm <= bus.col_major;
                row <= '0;
                col <= '0;
                idx <= '0;
            end else if (fire) begin
                idx <= idx + 1'b1;
                row <= row_step ? (row_end ? '0 : row + 1'b1) : row;
                col <= col_step ? (col_end ? '0 : col + 1'b1) : col;
            end
        end
    end
    // payload buffer needs no reset: every read is gated by the STREAM state
    always_ff @(posedge clk) begin
        if (take) tile_buf <= bus.tile_elements;
    end
endmodule
